// File: rtl/pkt_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_loader_pkg : shared loader state type and bus/size constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pkt_loader_pkg;

  localparam int   HDR_MAX_LEN = 16;
  localparam int   BYTE_BUS    = 8;
  localparam logic TRUE        = 1'b1;
  localparam logic FALSE       = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_proc_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_proc_hs : start/ready handshake with proc, done pulse         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module loader_proc_hs
  import pkt_loader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic proc_ready_i,
  output logic proc_start_o,
  output logic done_o,
  output logic release_o
);

  loader_state_t state_q, state_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= FALSE;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // WAIT_ACK ignores a ready left high by proc's previous packet.
  always_comb begin
    state_d      = state_q;
    done_d       = FALSE;
    release_o    = FALSE;
    proc_start_o = FALSE;
    case (state_q)
      IDLE: begin
        if (go_i) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        proc_start_o = TRUE;
        if (!proc_ready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        proc_start_o = TRUE;
        if (proc_ready_i) begin
          state_d   = IDLE;
          done_d    = TRUE;
          release_o = TRUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/pkt_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_loader : captures packet header bytes and hands them to proc.    |
// | Optional LOADER_STATS_EN adds packet/trunc/byte counters. Rev 1.0    |
// +----------------------------------------------------------------------+
module pkt_loader
  import pkt_loader_pkg::*;
#(
  parameter int HDR_MAX = HDR_MAX_LEN,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [BYTE_BUS-1:0] in_data_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [BYTE_BUS-1:0] pkt_hdr_o [0:HDR_MAX-1],
  output logic [LEN_W-1:0]    pkt_len_o,
  output logic                trunc_o,
  output logic                proc_start_o,
  input  logic                proc_ready_i,
  output logic                done_o
`ifdef LOADER_STATS_EN
  ,
  output logic [31:0]         stat_pkts_o,
  output logic [31:0]         stat_trunc_o,
  output logic [31:0]         stat_bytes_o
`endif
);

  localparam int               IDX_W     = (HDR_MAX > 1) ? $clog2(HDR_MAX) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] HDR_MAX_L = LEN_W'(HDR_MAX);

  // WAIT_ACK here spans both handshake phases; loader_proc_hs splits them.
  loader_state_t       state_q, state_d;
  logic [BYTE_BUS-1:0] hdr_q [0:HDR_MAX-1];
  logic [BYTE_BUS-1:0] hdr_d [0:HDR_MAX-1];
  logic [LEN_W-1:0]    len_q, len_d;
  logic                trunc_q, trunc_d;
  logic                in_ready_q, in_ready_d;
  logic                xfer_w, go_w, release_w;

  assign xfer_w = in_valid_i && in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hdr_q      <= '{default: '0};
      len_q      <= '0;
      trunc_q    <= FALSE;
      in_ready_q <= FALSE;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      in_ready_q <= in_ready_d;
    end
  end

  // len_q is zero in IDLE, so byte 0 shares the RECV write path.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    go_w    = FALSE;
    case (state_q)
      IDLE, RECV: begin
        if (xfer_w) begin
          if (len_q < HDR_MAX_L) hdr_d[len_q[IDX_W-1:0]] = in_data_i;
          else                   trunc_d = TRUE;
          if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
          if (in_last_i) begin
            state_d = WAIT_ACK;
            go_w    = TRUE;
          end else begin
            state_d = RECV;
          end
        end
      end
      WAIT_ACK: begin
        if (release_w) begin
          state_d = IDLE;
          hdr_d   = '{default: '0};
          len_d   = '0;
          trunc_d = FALSE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == RECV);
  end

  loader_proc_hs u_hs (
    .clk          (clk),
    .rst          (rst),
    .go_i         (go_w),
    .proc_ready_i (proc_ready_i),
    .proc_start_o (proc_start_o),
    .done_o       (done_o),
    .release_o    (release_w)
  );

  assign in_ready_o = in_ready_q;
  assign pkt_hdr_o  = hdr_q;
  assign pkt_len_o  = len_q;
  assign trunc_o    = trunc_q;

`ifdef LOADER_STATS_EN
  logic [31:0] stat_pkts_q, stat_trunc_q, stat_bytes_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
      stat_bytes_q <= '0;
    end else begin
      if (xfer_w) stat_bytes_q <= stat_bytes_q + 32'd1;
      if (release_w) begin
        stat_pkts_q <= stat_pkts_q + 32'd1;
        if (trunc_q) stat_trunc_q <= stat_trunc_q + 32'd1;
      end
    end
  end

  assign stat_pkts_o  = stat_pkts_q;
  assign stat_trunc_o = stat_trunc_q;
  assign stat_bytes_o = stat_bytes_q;
`endif

endmodule
`default_nettype wire

// File: doc/pkt_loader.md
Name: pkt_loader

Overview:
- Ingress stage directly upstream of proc.
- Accepts a byte stream with valid/ready/last and captures the first HDR_MAX bytes into a header buffer, which drives proc's pkt_hdr_i. Zero-pads short packets; discards bytes beyond HDR_MAX.
- Runs the start_i/ready_o handshake with proc and holds the buffer stable while proc runs.
- Back-pressures the stream until proc releases the buffer.

Parameters:
- HDR_MAX, `HDR_MAX_LEN, header buffer depth in bytes (must equal proc's).
- LEN_W, 16, width of packet byte counter and pkt_len_o.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid_i  in  1  stream byte valid
- in_data_i  in  8  stream byte
- in_last_i  in  1  last byte of packet
- in_ready_o  out  1  loader can accept a byte
- pkt_hdr_o  out  8 x HDR_MAX (unpacked [0:HDR_MAX-1])  header buffer, connects to proc pkt_hdr_i
- pkt_len_o  out  LEN_W  total byte count of current packet, saturating
- trunc_o  out  1  current packet exceeded HDR_MAX
- proc_start_o  out  1  to proc start_i
- proc_ready_i  in  1  from proc ready_o
- done_o  out  1  one-cycle pulse when proc finishes a packet

Behaviour:
- Reset: rst is synchronous, active-high; clk rising edge. On reset:
  - state=IDLE; all pkt_hdr_o bytes=0; pkt_len_o=0; trunc_o=0.
  - proc_start_o=0, done_o=0, in_ready_o=0. in_ready_o is registered and goes to 1 on the first cycle after reset.
- A byte transfers on a clk edge when in_valid_i && in_ready_o.
- IDLE: in_ready_o=1.
  - The first transfer writes byte 0 and sets pkt_len_o=1.
  - If in_last_i=1 on that transfer, go to WAIT_ACK; otherwise go to RECV.
- RECV: in_ready_o=1. Each transfer does the following:
  - If idx<HDR_MAX, write pkt_hdr_o[idx].
  - Otherwise set trunc_o=1 and discard the byte.
  - pkt_len_o increments, saturating at 2^LEN_W-1.
  - A transfer with in_last_i=1 moves to WAIT_ACK.
- WAIT_ACK: in_ready_o=0, proc_start_o=1. Wait for proc_ready_i==0, which confirms proc has latched start and cleared its stale ready_o. Then go to WAIT_DONE.
  - After reset proc_ready_i is already 0, so WAIT_ACK passes in 1 cycle. This is safe because proc cannot finish in zero cycles.
- WAIT_DONE: in_ready_o=0, proc_start_o=1. On proc_ready_i==1:
  - proc_start_o<=0, done_o<=1 for one cycle.
  - Clear all pkt_hdr_o bytes to 0, clear pkt_len_o and trunc_o.
  - Go to IDLE. proc returns to FREE one cycle after start drops.
- pkt_hdr_o, pkt_len_o and trunc_o are held constant throughout WAIT_ACK and WAIT_DONE. proc reads pkt_hdr_i combinationally during parse, match and exec.
- Minimum gap between the proc_start_o fall and the next rise is 1 cycle. This guarantees proc has returned to FREE.
- Boundary conditions:
  - Exactly HDR_MAX bytes: trunc_o stays 0.
  - HDR_MAX+1 bytes: trunc_o=1, the extra byte is dropped.
  - in_valid_i while in_ready_o=0: ignored; upstream must hold the byte.
  - in_last_i without in_valid_i: ignored.
  - Reset mid-packet or mid-handshake: immediate return to reset values. proc is reset by the same rst.
- Any illegal state encoding goes to IDLE.

Optional Feature:
- LOADER_STATS_EN defined adds three outputs:
  - stat_pkts_o, 32-bit: increments at each done_o.
  - stat_trunc_o, 32-bit: increments at each done_o where trunc_o=1.
  - stat_bytes_o, 32-bit: increments per transfer.
  - All wrap modulo 2^32 and reset to 0.
- Without the macro, these ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package/def.svh holds:
  - the loader state enum {IDLE, RECV, WAIT_ACK, WAIT_DONE};
  - HDR_MAX_LEN, BYTE_BUS, TRUE/FALSE (existing).
- Sub-module: loader_proc_hs, containing the WAIT_ACK/WAIT_DONE start/ready handshake FSM.
  - Inputs: go, proc_ready_i.
  - Outputs: proc_start_o, done pulse.
  - Reusable for any stage driving proc.

Test Plan:
- 3-byte packet AA BB CC with last on CC: bytes 0..2 = AA BB CC, rest 0; pkt_len_o=3; proc_start_o rises the cycle after last; in_ready_o=0 until done_o.
- HDR_MAX+5 bytes: the first HDR_MAX bytes are captured, trunc_o=1, pkt_len_o=HDR_MAX+5, and the buffer is unchanged by the extra bytes.
- Stale ready: proc model holds ready=1 from the previous packet, then drops it 1 cycle after start. The loader must not exit WAIT_ACK before ready=0, and done_o fires only on the next ready=1.
- Back-to-back packets with in_valid_i held high: second packet byte 0 is accepted ≥1 cycle after done_o; the buffer is zeroed beforehand; proc_start_o shows ≥1 low cycle.
- Reset asserted in RECV after 2 bytes and again in WAIT_DONE: all outputs return to reset values the next cycle; a following packet loads cleanly.
- LOADER_STATS_EN: 4 packets, one truncated, 100 total bytes → stat_pkts_o=4, stat_trunc_o=1, stat_bytes_o=100.
